// File: rtl/train_dispatcher.sv
// train_dispatcher: collects a departure-order pattern, streams it to a train checker and reports the verdict.
// Define TRAIN_DISPATCHER_PERM_CHECK_EN to validate the pattern as a permutation of 0..N-1 while in CHECK.
module train_dispatcher #(
   parameter int MAX_CARS = 10,
   parameter int TIMEOUT  = 127
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_valid,
   output logic       s_ready,
   input  logic [3:0] s_data,
   input  logic       s_last,
   output logic       t_in_valid,
   output logic [3:0] t_data,
   input  logic       t_out_valid,
   input  logic       t_result,
   output logic       r_valid,
   output logic       r_result,
   output logic       r_err,
   output logic [7:0] r_count
);
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, COLLECT, CHECK, SEND, WAIT, REPORT} state_t;
   state_t        r_state, w_next;
   logic [3:0]    r_buf [MAX_CARS];
   logic [3:0]    r_n, r_idx;
   logic          r_ovf, r_err_f, r_res;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_cnt;
   logic          w_acc;
`ifdef TRAIN_DISPATCHER_PERM_CHECK_EN
   logic [15:0]   r_seen;
   logic          w_bad;
   assign w_bad = (r_buf[r_idx] >= r_n) || r_seen[r_buf[r_idx]];
`endif
   assign s_ready    = rst_n && (r_state == IDLE || r_state == COLLECT);
   assign w_acc      = s_valid && s_ready;
   assign t_in_valid = r_state == SEND;
   assign t_data     = t_in_valid ? ((r_idx == 4'd0) ? r_n : r_buf[r_idx - 4'd1]) : 4'd0;
   assign r_valid    = r_state == REPORT;
   assign r_result   = r_valid && r_res;
   assign r_err      = r_valid && r_err_f;
   assign r_count    = r_cnt;
   // next-state selection; the first SEND beat is the length, so SEND runs N+1 cycles
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_acc ? (s_last ? CHECK : COLLECT) : IDLE;
         COLLECT: w_next = (w_acc && s_last) ? CHECK : COLLECT;
`ifdef TRAIN_DISPATCHER_PERM_CHECK_EN
         CHECK:   w_next = r_ovf ? REPORT : (r_idx != r_n - 4'd1) ? CHECK : (r_err_f || w_bad) ? REPORT : SEND;
`else
         CHECK:   w_next = r_ovf ? REPORT : SEND;
`endif
         SEND:    w_next = (r_idx == r_n) ? WAIT : SEND;
         WAIT:    w_next = (t_out_valid || r_tmo == TW'(TIMEOUT)) ? REPORT : WAIT;
         default: w_next = IDLE;
      endcase
   end
   // state, pattern buffer, flags and report counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_n     <= '0;
         r_idx   <= '0;
         r_ovf   <= 1'b0;
         r_err_f <= 1'b0;
         r_res   <= 1'b0;
         r_tmo   <= '0;
         r_cnt   <= '0;
         for (int i = 0; i < MAX_CARS; i++) r_buf[i] <= '0;
`ifdef TRAIN_DISPATCHER_PERM_CHECK_EN
         r_seen  <= '0;
`endif
      end else begin
         r_state <= w_next;
         r_idx   <= (w_next != r_state) ? 4'd0 : r_idx + 4'd1;
         r_tmo   <= (r_state == WAIT) ? r_tmo + 1'b1 : '0;
         if (w_next == REPORT) r_cnt <= r_cnt + 8'd1;
         if (w_acc) begin
            if (r_state == IDLE) begin
               r_buf[0] <= s_data;
               r_n      <= 4'd1;
               r_ovf    <= 1'b0;
               r_err_f  <= 1'b0;
               r_res    <= 1'b0;
`ifdef TRAIN_DISPATCHER_PERM_CHECK_EN
               r_seen   <= '0;
`endif
            end else if (r_n < 4'(MAX_CARS)) begin
               r_buf[r_n] <= s_data;
               r_n        <= r_n + 4'd1;
            end else begin
               r_ovf <= 1'b1;
            end
         end
`ifdef TRAIN_DISPATCHER_PERM_CHECK_EN
         if (r_state == CHECK) begin
            r_err_f              <= r_err_f | r_ovf | w_bad;
            r_seen[r_buf[r_idx]] <= 1'b1;
         end
`else
         if (r_state == CHECK) r_err_f <= r_ovf;
`endif
         if (r_state == WAIT) begin
            if (t_out_valid) r_res <= t_result;
            else if (r_tmo == TW'(TIMEOUT)) r_err_f <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_train_dispatcher.sv
// tb_train_dispatcher: table-driven bench for train_dispatcher plus reset and timeout sequences.
module tb_train_dispatcher;
   localparam int TIMEOUT = 127;
`ifdef TRAIN_DISPATCHER_PERM_CHECK_EN
   localparam bit PC = 1'b1;
`else
   localparam bit PC = 1'b0;
`endif
   logic       clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0;
   logic       t_out_valid = 1'b0, t_result = 1'b0;
   logic [3:0] s_data = '0;
   logic       s_ready, t_in_valid, r_valid, r_result, r_err;
   logic [3:0] t_data;
   logic [7:0] r_count;
   int total = 0, bad = 0, exp_cnt = 0;
   typedef struct {
      int          nb;
      logic [63:0] beats;
      int          resp;
      int          dly;
      bit          noise;
      int          elen;
      logic [63:0] estr;
      bit          eres;
      bit          eerr;
      int          elat;
   } vec_t;
   vec_t vt[10];
   train_dispatcher #(.MAX_CARS(10), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .t_in_valid(t_in_valid), .t_data(t_data), .t_out_valid(t_out_valid),
      .t_result(t_result), .r_valid(r_valid), .r_result(r_result), .r_err(r_err), .r_count(r_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask
   task automatic run_vec(input int k, input vec_t v);
      logic [63:0] got = '0;
      int len = 0, cyc = 1, wstart = 0, first = 0, lat = -1;
      bit rdy = 1, done = 0, ended = 0, sent = 0, pulsed = 0, zbad = 0, gap = 0;
      logic gres = 0, gerr = 0;
      logic [7:0] gcnt = '0;
      if (v.noise) begin
         t_out_valid = 1'b1;
         t_result    = (v.resp == 0);
      end
      for (int i = 0; i < v.nb; i++) begin
         s_valid = 1'b1;
         s_data  = v.beats[4*i +: 4];
         s_last  = (i == v.nb - 1);
         rdy     = rdy & s_ready;
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      while (!done && cyc < 400) begin
         if (pulsed) begin
            t_out_valid = 1'b0;
            t_result    = 1'b0;
            pulsed      = 0;
         end
         if (t_in_valid) begin
            if (ended) gap = 1;
            if (len == 0) first = cyc;
            if (len < 16) got[4*len +: 4] = t_data;
            len++;
         end else begin
            if (t_data != 4'd0) zbad = 1;
            if (len > 0 && !ended) begin
               ended  = 1;
               wstart = cyc;
            end
         end
         if (ended && v.resp >= 0 && !sent && cyc - wstart == v.dly) begin
            t_out_valid = 1'b1;
            t_result    = v.resp[0];
            sent        = 1;
            pulsed      = 1;
         end
         if (r_valid) begin
            done = 1;
            gres = r_result;
            gerr = r_err;
            gcnt = r_count;
            if (ended) lat = cyc - wstart;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      t_out_valid = 1'b0;
      t_result    = 1'b0;
      exp_cnt++;
      chk($sformatf("v%0d_report_seen", k), 64'(done), 64'd1);
      chk($sformatf("v%0d_s_ready_beats", k), 64'(rdy), 64'd1);
      chk($sformatf("v%0d_stream_len", k), 64'(len), 64'(v.elen));
      chk($sformatf("v%0d_stream", k), got, v.estr);
      chk($sformatf("v%0d_r_result", k), 64'(gres), 64'(v.eres));
      chk($sformatf("v%0d_r_err", k), 64'(gerr), 64'(v.eerr));
      chk($sformatf("v%0d_r_count", k), 64'(gcnt), 64'(exp_cnt[7:0]));
      chk($sformatf("v%0d_idle_data_zero", k), 64'(zbad), 64'd0);
      chk($sformatf("v%0d_burst_contig", k), 64'(gap), 64'd0);
      if (v.elen > 0) chk($sformatf("v%0d_check_latency", k), 64'(first), 64'(PC ? v.nb + 1 : 2));
      if (v.elat >= 0) chk($sformatf("v%0d_wait_to_report", k), 64'(lat), 64'(v.elat));
      @(negedge clk);
      chk($sformatf("v%0d_single_pulse", k), 64'({r_valid, r_result, r_err}), 64'd0);
   endtask
   initial begin
      int n;
      bit rv;
      vt[0] = '{3, 64'h012, 1, 2, 0, 4, 64'h0123, 1, 0, -1};
      vt[1] = '{1, 64'h0, 0, 0, 0, 2, 64'h01, 0, 0, -1};
      vt[2] = '{12, 64'hBA9876543210, 1, 0, 0, 0, 64'h0, 0, 1, -1};
      if (PC) vt[3] = '{3, 64'h011, 1, 1, 0, 0, 64'h0, 0, 1, -1};
      else    vt[3] = '{3, 64'h011, 1, 1, 0, 4, 64'h0113, 1, 0, -1};
      vt[4] = '{2, 64'h01, 1, 0, 1, 3, 64'h012, 1, 0, -1};
      vt[5] = '{10, 64'h0123456789, 0, 5, 0, 11, 64'h0123456789A, 0, 0, -1};
      vt[6] = '{11, 64'hA9876543210, 1, 0, 0, 0, 64'h0, 0, 1, -1};
      if (PC) vt[7] = '{3, 64'h130, 1, 0, 0, 0, 64'h0, 0, 1, -1};
      else    vt[7] = '{3, 64'h130, 1, 0, 0, 4, 64'h1303, 1, 0, -1};
      vt[8] = '{1, 64'h0, -1, 0, 0, 2, 64'h01, 0, 1, TIMEOUT + 1};
      vt[9] = '{2, 64'h10, 1, 3, 0, 3, 64'h102, 1, 0, -1};
      repeat (3) @(negedge clk);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_t_side", 64'({t_in_valid, t_data}), 64'd0);
      chk("rst_report", 64'({r_valid, r_result, r_err}), 64'd0);
      chk("rst_r_count", 64'(r_count), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_s_ready", 64'(s_ready), 64'd1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = 4'(2 - i);
         s_last  = (i == 2);
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      n = 0;
      for (int c = 0; c < 20 && n < 2; c++) begin
         if (t_in_valid) n++;
         if (n < 2) @(negedge clk);
      end
      chk("midsend_reached_cycle2", 64'(n), 64'd2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midsend_t_in_valid", 64'(t_in_valid), 64'd0);
      chk("midsend_no_report", 64'(r_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("midsend_s_ready_after", 64'(s_ready), 64'd1);
      rv = 0;
      repeat (10) begin
         @(negedge clk);
         rv = rv | r_valid | t_in_valid;
      end
      chk("midsend_stays_idle", 64'(rv), 64'd0);
      chk("midsend_r_count", 64'(r_count), 64'd0);
      for (int k = 0; k < 10; k++) run_vec(k, vt[k]);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
